// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one 64-bit DataMemory between two requesters. Misaligned
//            requests are rejected locally. Define DMEM_ARB_RR_EN for
//            round-robin ties; otherwise port 0 has fixed priority.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int DMEM_ADDRESS_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          p0_req,
  input  logic [DMEM_ADDRESS_WIDTH-1:0] p0_address,
  input  logic [63:0]                   p0_data_in,
  input  logic [7:0]                    p0_bytemask,
  input  logic                          p0_write,
  output logic                          p0_done,
  output logic                          p0_err,
  output logic [63:0]                   p0_data_out,
  input  logic                          p1_req,
  input  logic [DMEM_ADDRESS_WIDTH-1:0] p1_address,
  input  logic [63:0]                   p1_data_in,
  input  logic [7:0]                    p1_bytemask,
  input  logic                          p1_write,
  output logic                          p1_done,
  output logic                          p1_err,
  output logic [63:0]                   p1_data_out,
  output logic                          grant,
  output logic [DMEM_ADDRESS_WIDTH-1:0] mem_address,
  output logic [63:0]                   mem_data_in,
  output logic [7:0]                    mem_bytemask,
  output logic                          mem_write,
  output logic                          mem_start_access,
  input  logic                          mem_access_done,
  input  logic [63:0]                   mem_data_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                    state_q;
  logic [1:0]                    state_d;
  logic [DMEM_ADDRESS_WIDTH-1:0] cmd_address;
  logic [63:0]                   cmd_data_in;
  logic [7:0]                    cmd_bytemask;
  logic                          cmd_write;
  logic [63:0]                   rdata_q;
  logic                          err_q;
  logic                          grant_q;
  logic                          winner;
  logic                          take;
  logic                          win_misaligned;
  logic [DMEM_ADDRESS_WIDTH-1:0] win_address;
  logic [63:0]                   win_data_in;
  logic [7:0]                    win_bytemask;
  logic                          win_write;

`ifdef DMEM_ARB_RR_EN
  // Resets to 1 so that port 0 wins the first contested grant.
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (take) begin
      last_grant <= winner;
    end
  end

  always_comb begin
    if (p0_req && p1_req) begin
      winner = ~last_grant;
    end else begin
      winner = ~p0_req;
    end
  end
`else
  always_comb begin
    winner = ~p0_req;
  end
`endif

  always_comb begin
    win_address    = winner ? p1_address  : p0_address;
    win_data_in    = winner ? p1_data_in  : p0_data_in;
    win_bytemask   = winner ? p1_bytemask : p0_bytemask;
    win_write      = winner ? p1_write    : p0_write;
    win_misaligned = |win_address[2:0];
    take           = (state_q == ST_IDLE) && (p0_req || p1_req);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (p0_req || p1_req) state_d = win_misaligned ? ST_DONE : ST_BUSY;
      ST_BUSY: if (mem_access_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_start_access = (state_q == ST_BUSY);
    p0_done          = (state_q == ST_DONE) && !grant_q;
    p1_done          = (state_q == ST_DONE) &&  grant_q;
    p0_err           = p0_done && err_q;
    p1_err           = p1_done && err_q;
    p0_data_out      = rdata_q;
    p1_data_out      = rdata_q;
    grant            = grant_q;
    mem_address      = cmd_address;
    mem_data_in      = cmd_data_in;
    mem_bytemask     = cmd_bytemask;
    mem_write        = cmd_write;
  end

  // Command is frozen from the grant until the next grant, keeping mem_* stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_address  <= '0;
      cmd_data_in  <= '0;
      cmd_bytemask <= '0;
      cmd_write    <= 1'b0;
      err_q        <= 1'b0;
      grant_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (take) begin
        cmd_address  <= win_address;
        cmd_data_in  <= win_data_in;
        cmd_bytemask <= win_bytemask;
        cmd_write    <= win_write;
        err_q        <= win_misaligned;
        grant_q      <= winner;
      end
      if ((state_q == ST_BUSY) && mem_access_done && !cmd_write) begin
        rdata_q <= mem_data_out;
      end
    end
  end

endmodule
`default_nettype wire
